// File: rtl/fpu_pkg.sv
// Shared FPU constants and FSM state type for the sequential divider.
// Optional rounding in fdiv_seq is selected by the FDIV_ROUND_EN macro.
package fpu_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 23;
  localparam int unsigned QB      = MAN_W + 3;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    PACK
  } state_t;

endpackage

// File: rtl/fdiv_seq_if.sv
// Start/done request bus of the sequential divider: master drives operands,
// slave returns the quotient and flags.
interface fdiv_seq_if;

  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] y;
  logic        error;
  logic        overflow;

  modport master (
    output start, a, b,
    input  busy, done, y, error, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, y, error, overflow
  );

endinterface

// File: rtl/fdiv_mant_iter.sv
// One restoring division step: subtract divisor, keep or restore, shift left.
module fdiv_mant_iter
  import fpu_pkg::*;
(
  input  logic [MAN_W+1:0] i_rem,
  input  logic [MAN_W:0]   i_div,
  output logic [MAN_W+1:0] o_rem,
  output logic             o_qbit
);

  logic [MAN_W+2:0] w_diff;

  assign w_diff = {1'b0, i_rem} - {2'b00, i_div};
  assign o_qbit = ~w_diff[MAN_W+2];
  // Top bit of the kept value is always zero, so the shift drops nothing.
  assign o_rem  = (o_qbit ? w_diff[MAN_W+1:0] : i_rem) << 1;

endmodule

// File: rtl/fdiv_seq.sv
// Iterative IEEE-754 single-precision divider, one quotient bit per clock.
// Define FDIV_ROUND_EN for round-to-nearest-even; default build truncates.
module fdiv_seq
  import fpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  fdiv_seq_if.slave  bus
);

  state_t              r_state;
  logic [4:0]          r_step;
  logic                r_sign;
  logic [EXP_W-1:0]    r_ea;
  logic [EXP_W-1:0]    r_eb;
  logic [MAN_W-1:0]    r_fa;
  logic [MAN_W-1:0]    r_fb;
  logic signed [9:0]   r_exp;
  logic [MAN_W+1:0]    r_rem;
  logic [MAN_W:0]      r_div;
  logic [QB-1:0]       r_q;
  logic                r_busy;
  logic                r_done;
  logic [31:0]         r_y;
  logic                r_err;
  logic                r_ovf;

  logic [MAN_W+1:0]    w_rem_nxt;
  logic                w_qbit;
  logic [QB-2:0]       w_norm;
  logic signed [9:0]   w_exp_n;
  logic signed [9:0]   w_exp_f;
  logic [MAN_W-1:0]    w_frac;
  logic [31:0]         w_y;
  logic                w_err;
  logic                w_ovf;

  fdiv_mant_iter u_iter (
    .i_rem  (r_rem),
    .i_div  (r_div),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  assign w_norm  = r_q[QB-1] ? r_q[QB-2:0] : {r_q[QB-3:0], 1'b0};
  assign w_exp_n = r_q[QB-1] ? r_exp : r_exp - 10'sd1;

`ifdef FDIV_ROUND_EN
  logic          w_sticky;
  logic          w_rup;
  logic [MAN_W:0] w_mant_r;

  assign w_sticky = |r_rem;
  assign w_rup    = w_norm[1] & (w_norm[0] | w_sticky | w_norm[2]);
  assign w_mant_r = {1'b0, w_norm[QB-2:2]} + {{MAN_W{1'b0}}, w_rup};
  assign w_frac   = w_mant_r[MAN_W-1:0];
  // Carry out of the mantissa leaves w_frac at zero and bumps the exponent.
  assign w_exp_f  = w_mant_r[MAN_W] ? w_exp_n + 10'sd1 : w_exp_n;
`else
  logic w_unused_grs;

  assign w_frac       = w_norm[QB-2:2];
  assign w_exp_f      = w_exp_n;
  assign w_unused_grs = ^w_norm[1:0];
`endif

  always_comb begin
    w_y   = {r_sign, w_exp_f[EXP_W-1:0], w_frac};
    w_err = 1'b0;
    w_ovf = 1'b0;
    if (r_ea == EXP_W'(EXP_MAX) || r_eb == EXP_W'(EXP_MAX)) begin
      w_y   = QNAN;
      w_err = 1'b1;
    end else if (r_eb == '0) begin
      w_y   = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_err = 1'b1;
    end else if (r_ea == '0) begin
      w_y   = {r_sign, 31'd0};
    end else if (w_exp_f > 10'sd254) begin
      w_y   = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_ovf = 1'b1;
    end else if (w_exp_f < 10'sd1) begin
      w_y   = {r_sign, 31'd0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_sign  <= 1'b0;
      r_ea    <= '0;
      r_eb    <= '0;
      r_fa    <= '0;
      r_fb    <= '0;
      r_exp   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y     <= '0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          // busy still covers the done cycle, so a start there is not taken.
          if (r_busy) begin
            r_busy <= 1'b0;
          end else if (bus.start) begin
            r_busy  <= 1'b1;
            r_sign  <= bus.a[31] ^ bus.b[31];
            r_ea    <= bus.a[30:23];
            r_eb    <= bus.b[30:23];
            r_fa    <= bus.a[22:0];
            r_fb    <= bus.b[22:0];
            r_step  <= '0;
            r_state <= DIV;
          end
        end
        DIV: begin
          // Step 0 is the unpack cycle; steps 1..QB each retire one quotient bit.
          if (r_step == '0) begin
            r_rem <= {2'b01, r_fa};
            r_div <= {1'b1, r_fb};
            r_exp <= $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) + $signed(10'(BIAS));
            r_q   <= '0;
          end else begin
            r_rem <= w_rem_nxt;
            r_q   <= {r_q[QB-2:0], w_qbit};
          end
          if (r_step == 5'(QB)) begin
            r_state <= PACK;
          end
          r_step <= r_step + 5'd1;
        end
        PACK: begin
          r_y     <= w_y;
          r_err   <= w_err;
          r_ovf   <= w_ovf;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.y        = r_y;
  assign bus.error    = r_err;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: directed cases plus random operands
// compared against an integer-arithmetic reference of the division rules.
module tb_fdiv_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fdiv_seq_if bus ();

  fdiv_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned n_done  = 0;

  always @(negedge clk) if (bus.done === 1'b1) n_done <= n_done + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {error, overflow, y}.
  function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        sign;
    int          ea, eb, e;
    logic [63:0] num, den, q, rem;
    logic [31:0] mant;
    sign = a[31] ^ b[31];
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {2'b10, 32'h7FC0_0000};
    if (eb == 0) return {2'b10, sign, 8'hFF, 23'd0};
    if (ea == 0) return {2'b00, sign, 31'd0};
    num = {40'd0, 1'b1, a[22:0]} << 25;
    den = {40'd0, 1'b1, b[22:0]};
    q   = num / den;
    rem = num % den;
    e   = ea - eb + 127;
    if (q < (64'd1 << 25)) begin
      q = q << 1;
      e = e - 1;
    end
    mant = 32'(q >> 2) & 32'h007F_FFFF;
`ifdef FDIV_ROUND_EN
    if (q[1] && (q[0] || rem != 0 || mant[0])) begin
      mant = mant + 1;
      if (mant == 32'h0080_0000) begin
        mant = 0;
        e = e + 1;
      end
    end
`endif
    if (e > 254) return {2'b01, sign, 8'hFF, 23'd0};
    if (e < 1) return {2'b00, sign, 31'd0};
    return {2'b00, sign, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    int unsigned sel;
    logic [7:0]  e;
    logic [22:0] f;
    sel = $urandom_range(0, 19);
    f   = 23'($urandom);
    if (sel == 0)       e = 8'h00;
    else if (sel == 1)  e = 8'hFF;
    else if (sel < 12)  e = 8'($urandom_range(110, 144));
    else                e = 8'($urandom_range(1, 254));
    if (sel == 2) f = '1;
    return {1'($urandom), e, f};
  endfunction

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int inj, input logic [31:0] ia, input logic [31:0] ib,
                           output logic [31:0] y, output logic [1:0] flags,
                           output int lat, output logic busy_ok);
    lat     = 999;
    busy_ok = 1'b1;
    y       = '0;
    flags   = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == inj) begin
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        lat   = cyc;
        y     = bus.y;
        flags = {bus.error, bus.overflow};
        break;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [33:0] exp, input int inj,
                       input logic [31:0] ia, input logic [31:0] ib);
    logic [31:0] y;
    logic [1:0]  flags;
    int          lat;
    logic        busy_ok;
    launch(a, b);
    wait_done(inj, ia, ib, y, flags, lat, busy_ok);
    chk($sformatf("%s.lat a=%h b=%h", tag, a, b), 32'(lat), 32'd28);
    chk($sformatf("%s.busy a=%h b=%h", tag, a, b), {31'd0, busy_ok}, 32'd1);
    chk($sformatf("%s.y a=%h b=%h", tag, a, b), y, exp[31:0]);
    chk($sformatf("%s.flags a=%h b=%h", tag, a, b), {30'd0, flags}, {30'd0, exp[33:32]});
    if (lat != 999) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s.release", tag), {30'd0, bus.busy, bus.done}, 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned nd;
    logic [31:0] ra, rb;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.y", bus.y, 32'd0);
    chk("reset.ctl", {28'd0, bus.busy, bus.done, bus.error, bus.overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("six_by_two", 32'h40C0_0000, 32'h4000_0000, {2'b00, 32'h4040_0000}, 0, '0, '0);
`ifdef FDIV_ROUND_EN
    do_op("third", 32'h3F80_0000, 32'h4040_0000, {2'b00, 32'h3EAA_AAAB}, 0, '0, '0);
`else
    do_op("third", 32'h3F80_0000, 32'h4040_0000, {2'b00, 32'h3EAA_AAAA}, 0, '0, '0);
`endif
    do_op("div_zero", 32'h3F80_0000, 32'h0000_0000, {2'b10, 32'h7F80_0000}, 0, '0, '0);
    do_op("nan_in", 32'h7FC0_0000, 32'h3F80_0000, {2'b10, 32'h7FC0_0000}, 0, '0, '0);
    do_op("ovf", 32'h7F00_0000, 32'h3E80_0000, {2'b01, 32'h7F80_0000}, 0, '0, '0);
    do_op("neg_half", 32'hBF80_0000, 32'h4000_0000, {2'b00, 32'hBF00_0000}, 0, '0, '0);

    nd = n_done;
`ifdef FDIV_ROUND_EN
    do_op("ignored", 32'h3F80_0000, 32'h4040_0000, {2'b00, 32'h3EAA_AAAB}, 5,
          32'h40C0_0000, 32'h4000_0000);
`else
    do_op("ignored", 32'h3F80_0000, 32'h4040_0000, {2'b00, 32'h3EAA_AAAA}, 5,
          32'h40C0_0000, 32'h4000_0000);
`endif
    repeat (35) @(posedge clk);
    #1;
    chk("ignored.ndone", n_done - nd, 32'd1);

    launch(32'h40C0_0000, 32'h4000_0000);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.y", bus.y, 32'd0);
    chk("abort.ctl", {28'd0, bus.busy, bus.done, bus.error, bus.overflow}, 32'd0);
    nd = n_done;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort.ndone", n_done - nd, 32'd0);
    do_op("after_abort", 32'h40C0_0000, 32'h4000_0000, {2'b00, 32'h4040_0000}, 0, '0, '0);

    for (int i = 0; i < 250; i++) begin
      ra = rnd_fp();
      rb = rnd_fp();
      do_op("rnd", ra, rb, ref_div(ra, rb), 0, '0, '0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
